// File: rtl/spike_wave_scheduler_if.sv
// Bundle of per-network input handshakes and the column-facing output bus
// of the spike wave scheduler. The master side is the spike source and column;
// the slave side is the scheduler itself.
interface spike_wave_scheduler_if #(
    parameter int P   = 64,
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [N-1:0][P-1:0] data_in;
    logic [P-1:0]        data_out;
    logic                out_valid;
    logic                wave_start;
    logic [IDW-1:0]      out_net_id;
    logic                col_rstb;

    modport master (
        output in_valid,
        output data_in,
        input  in_ready,
        input  data_out,
        input  out_valid,
        input  wave_start,
        input  out_net_id,
        input  col_rstb
    );

    modport slave (
        input  in_valid,
        input  data_in,
        output in_ready,
        output data_out,
        output out_valid,
        output wave_start,
        output out_net_id,
        output col_rstb
    );
endinterface

// File: rtl/spike_wave_scheduler.sv
// spike_wave_scheduler: N per-network frame FIFOs feeding one shared column.
// A network is granted once it holds a full wave of WAVE_LEN frames; the wave is
// streamed frame-per-cycle, followed by GAP cycles with the column held in reset.
// Optional build macro: FIXED_PRIO_EN (lowest-index eligible network always wins;
// without it the grant is round-robin and starvation-free).
module spike_wave_scheduler #(
    parameter int P        = 64,
    parameter int N        = 4,
    parameter int DEPTH    = 16,
    parameter int WAVE_LEN = 8,
    parameter int GAP      = 2
) (
    input  logic                   clk,
    input  logic                   grst,
    spike_wave_scheduler_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int IDW = $clog2(N);
    localparam int BW  = $clog2(WAVE_LEN + 1);
    localparam int GW  = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t state_r, state_n;

    logic [P-1:0]   mem_r    [N][DEPTH];
    logic [AW-1:0]  wr_ptr_r [N];
    logic [AW-1:0]  rd_ptr_r [N];
    logic [CW-1:0]  count_r  [N];

    logic [N-1:0]   push_s;
    logic [N-1:0]   pop_s;
    logic [N-1:0]   ready_s;
    logic [N-1:0]   eligible_s;

    logic           found_s;
    logic [IDW-1:0] grant_s;
    logic [IDW-1:0] gnt_r;
    logic [IDW-1:0] rr_r;
    logic [BW-1:0]  beat_r;
    logic [GW-1:0]  gap_r;

    logic [P-1:0]   data_out_r;
    logic           out_valid_r;
    logic           wave_start_r;
    logic           col_rstb_r;

    // Per-network handshake decode: ready from the registered count, pop only for the granted FIFO while streaming.
    always_comb begin
        push_s     = {N{1'b0}};
        pop_s      = {N{1'b0}};
        ready_s    = {N{1'b0}};
        eligible_s = {N{1'b0}};
        for (int n = 0; n < N; n++) begin
            ready_s[n]    = (count_r[n] != CW'(DEPTH));
            push_s[n]     = bus.in_valid[n] && ready_s[n];
            pop_s[n]      = (state_r == S_STREAM) && (gnt_r == IDW'(n));
            eligible_s[n] = (count_r[n] >= CW'(WAVE_LEN));
        end
    end

    // Frame storage; not reset because pointers and counts define what is live.
    always_ff @(posedge clk) begin
        for (int n = 0; n < N; n++) begin
            if (push_s[n]) begin
                mem_r[n][wr_ptr_r[n]] <= bus.data_in[n];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        for (int n = 0; n < N; n++) begin
            if (grst) begin
                wr_ptr_r[n] <= {AW{1'b0}};
                rd_ptr_r[n] <= {AW{1'b0}};
                count_r[n]  <= {CW{1'b0}};
            end else begin
                if (push_s[n]) begin
                    wr_ptr_r[n] <= wr_ptr_r[n] + 1'b1;
                end
                if (pop_s[n]) begin
                    rd_ptr_r[n] <= rd_ptr_r[n] + 1'b1;
                end
                case ({push_s[n], pop_s[n]})
                    2'b10:   count_r[n] <= count_r[n] + 1'b1;
                    2'b01:   count_r[n] <= count_r[n] - 1'b1;
                    default: count_r[n] <= count_r[n];
                endcase
            end
        end
    end

    // Arbiter: pick the network to grant among those holding a complete wave.
    always_comb begin
        found_s = 1'b0;
        grant_s = {IDW{1'b0}};
`ifdef FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible_s[IDW'(i)]) begin
                found_s = 1'b1;
                grant_s = IDW'(i);
            end else begin
                found_s = found_s;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!found_s && eligible_s[IDW'((int'(rr_r) + i) % N)]) begin
                found_s = 1'b1;
                grant_s = IDW'((int'(rr_r) + i) % N);
            end else begin
                found_s = found_s;
            end
        end
`endif
    end

    // Next-state logic for the IDLE -> STREAM -> GAP cycle.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                if (found_s) begin
                    state_n = S_STREAM;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_STREAM: begin
                if (beat_r == BW'(WAVE_LEN - 1)) begin
                    state_n = S_GAP;
                end else begin
                    state_n = S_STREAM;
                end
            end
            S_GAP: begin
                if (gap_r == GW'(GAP - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_GAP;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (grst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Grant, round-robin pointer and beat/gap counters.
    always_ff @(posedge clk) begin
        if (grst) begin
            gnt_r  <= {IDW{1'b0}};
            rr_r   <= {IDW{1'b0}};
            beat_r <= {BW{1'b0}};
            gap_r  <= {GW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    beat_r <= {BW{1'b0}};
                    gap_r  <= {GW{1'b0}};
                    if (found_s) begin
                        gnt_r <= grant_s;
`ifdef FIXED_PRIO_EN
                        rr_r  <= {IDW{1'b0}};
`else
                        rr_r  <= (grant_s == IDW'(N - 1)) ? {IDW{1'b0}} : grant_s + 1'b1;
`endif
                    end
                end
                S_STREAM: begin
                    if (beat_r == BW'(WAVE_LEN - 1)) begin
                        beat_r <= {BW{1'b0}};
                    end else begin
                        beat_r <= beat_r + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_r == GW'(GAP - 1)) begin
                        gap_r <= {GW{1'b0}};
                    end else begin
                        gap_r <= gap_r + 1'b1;
                    end
                end
                default: begin
                    beat_r <= {BW{1'b0}};
                    gap_r  <= {GW{1'b0}};
                end
            endcase
        end
    end

    // Registered column outputs: a popped frame appears the cycle after its pop.
    always_ff @(posedge clk) begin
        if (grst) begin
            data_out_r   <= {P{1'b0}};
            out_valid_r  <= 1'b0;
            wave_start_r <= 1'b0;
            col_rstb_r   <= 1'b0;
        end else begin
            if (state_r == S_STREAM) begin
                data_out_r <= mem_r[gnt_r][rd_ptr_r[gnt_r]];
            end else begin
                data_out_r <= {P{1'b0}};
            end
            out_valid_r  <= (state_r == S_STREAM);
            wave_start_r <= (state_r == S_STREAM) && (beat_r == {BW{1'b0}});
            col_rstb_r   <= (state_r != S_GAP);
        end
    end

    assign bus.in_ready   = ready_s;
    assign bus.data_out   = data_out_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.wave_start = wave_start_r;
    assign bus.out_net_id = gnt_r;
    assign bus.col_rstb   = col_rstb_r;

endmodule
